// File: rtl/class_pkg.sv
// Shared types and constants for the classifier result stage.
package class_pkg;

  localparam int CLASS_KEY_LEN   = 276;
  localparam int CLASS_VT_AWIDTH = 15;

  // Resolved hash-side result for one lookup.
  typedef struct packed {
    logic                       hit;
    logic                       err;
    logic [CLASS_VT_AWIDTH-1:0] ptr;
  } hash_res_t;

  // TCAM result for one packet.
  typedef struct packed {
    logic                       hit;
    logic                       err;
    logic [CLASS_VT_AWIDTH-1:0] ptr;
  } tcam_res_t;

endpackage

// File: rtl/class_res_fifo.sv
// Small show-ahead result FIFO with full/empty flags. A push while full is
// accepted only when a pop frees a slot in the same cycle.
module class_res_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  T     din_i,
  input  logic pop_i,
  output T     dout_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW + 1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign dout_o  = mem_q[rd_q];

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
      end
      if (do_pop) rd_q <= (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (!do_push && do_pop) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/class_key_resolve.sv
// Classifier result stage: compares value-memory keys per bucket way, folds
// in bucket and TCAM errors, and merges hash and TCAM results in order.
module class_key_resolve
  import class_pkg::*;
#(
  parameter int KEY_LEN   = CLASS_KEY_LEN,
  parameter int VT_AWIDTH = CLASS_VT_AWIDTH,  // must match CLASS_VT_AWIDTH
  parameter int NUM_WAYS  = 4,
  parameter int VM_LAT    = 4,
  parameter int RES_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pkt_strobe,
  input  logic                 pkt_hbkt_err,
  input  logic                 way_vld,
  input  logic [VT_AWIDTH-1:0] val_ptr,
  input  logic [KEY_LEN-1:0]   key_orig,
  input  logic [KEY_LEN-1:0]   val_mem_dout_q,
  input  logic                 of_tcam_vld,
  input  logic                 of_tcam_err,
  input  logic                 of_tcam_hit_miss,
  input  logic [VT_AWIDTH-1:0] tcam_ptr,
  output logic                 final_vld,
  output logic                 final_err,
  output logic                 final_hit_miss,
  output logic                 final_src,
  output logic [VT_AWIDTH-1:0] final_ptr,
  output logic                 proto_err,
  output logic                 ovf_err
);

  localparam int CNT_W = 4;  // enough for beat indices 0..7

  typedef struct packed {
    logic                 act;
    logic                 first;
    logic                 last;
    logic                 hbkt;
    logic                 way_vld;
    logic [VT_AWIDTH-1:0] ptr;
    logic [KEY_LEN-1:0]   key;
  } beat_t;

  logic [CNT_W-1:0] cnt_q, cnt_d, beat_idx;
  logic             busy, start, beat_last;
  beat_t            beat_in, aligned;
  beat_t            dl_q [VM_LAT];

  logic                 cmp_q, st_act_q, st_first_q, st_last_q, st_hbkt_q;
  logic [VT_AWIDTH-1:0] st_ptr_q;
  logic                 acc_hit_q, acc_multi_q, acc_hbkt_q;
  logic                 acc_hit_d, acc_multi_d, acc_hbkt_d;
  logic [VT_AWIDTH-1:0] acc_ptr_q, acc_ptr_d;

  hash_res_t hash_din, hash_dout;
  tcam_res_t tcam_din, tcam_dout;
  logic      hash_push, hash_full, hash_empty, tcam_full, tcam_empty, pop;
  logic      proto_err_q, ovf_err_q;

  assign busy      = (cnt_q != '0);
  assign start     = pkt_strobe & ~busy;
  assign beat_idx  = start ? '0 : cnt_q;
  assign beat_last = (beat_idx == CNT_W'(NUM_WAYS - 1));

  // Beat counter: a strobe while idle opens NUM_WAYS consecutive beats.
  always_comb begin
    cnt_d = cnt_q;
    if (start)     cnt_d = (NUM_WAYS > 1) ? CNT_W'(1) : '0;
    else if (busy) cnt_d = beat_last ? '0 : cnt_q + 1'b1;
  end

  // Bundle this beat's context for the trip through the delay line.
  always_comb begin
    beat_in         = '0;
    beat_in.act     = start | busy;
    beat_in.first   = start;
    beat_in.last    = (start | busy) & beat_last;
    beat_in.hbkt    = start & pkt_hbkt_err;
    beat_in.way_vld = (start | busy) & way_vld;
    beat_in.ptr     = val_ptr;
    beat_in.key     = key_orig;
  end

  assign aligned = dl_q[VM_LAT-1];

  // Counter, delay line aligned with memory read data, and registered compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      for (int i = 0; i < VM_LAT; i++) dl_q[i] <= '0;
      cmp_q      <= 1'b0;
      st_act_q   <= 1'b0;
      st_first_q <= 1'b0;
      st_last_q  <= 1'b0;
      st_hbkt_q  <= 1'b0;
      st_ptr_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      dl_q[0] <= beat_in;
      for (int i = 1; i < VM_LAT; i++) dl_q[i] <= dl_q[i-1];
      cmp_q      <= aligned.act & aligned.way_vld & (val_mem_dout_q == aligned.key);
      st_act_q   <= aligned.act;
      st_first_q <= aligned.first;
      st_last_q  <= aligned.last;
      st_hbkt_q  <= aligned.hbkt;
      st_ptr_q   <= aligned.ptr;
    end
  end

  // Fold this beat's compare into the lookup; first match wins the pointer.
  always_comb begin
    acc_hit_d   = acc_hit_q;
    acc_ptr_d   = acc_ptr_q;
    acc_multi_d = acc_multi_q;
    acc_hbkt_d  = acc_hbkt_q;
    if (st_act_q) begin
      if (st_first_q) begin
        acc_hit_d   = cmp_q;
        acc_ptr_d   = cmp_q ? st_ptr_q : '0;
        acc_multi_d = 1'b0;
        acc_hbkt_d  = st_hbkt_q;
      end else begin
        acc_multi_d = acc_multi_q | (acc_hit_q & cmp_q);
        if (cmp_q && !acc_hit_q) acc_ptr_d = st_ptr_q;
        acc_hit_d   = acc_hit_q | cmp_q;
      end
    end
  end

  assign hash_push    = st_act_q & st_last_q;
  assign hash_din.hit = acc_hit_d;
  assign hash_din.err = acc_multi_d | acc_hbkt_d;
  assign hash_din.ptr = acc_ptr_d;
  assign tcam_din.hit = of_tcam_hit_miss;
  assign tcam_din.err = of_tcam_err;
  assign tcam_din.ptr = tcam_ptr;
  assign pop          = ~hash_empty & ~tcam_empty;

  class_res_fifo #(.DEPTH(RES_DEPTH), .T(hash_res_t)) u_hash_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (hash_push),
    .din_i   (hash_din),
    .pop_i   (pop),
    .dout_o  (hash_dout),
    .full_o  (hash_full),
    .empty_o (hash_empty)
  );

  class_res_fifo #(.DEPTH(RES_DEPTH), .T(tcam_res_t)) u_tcam_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (of_tcam_vld),
    .din_i   (tcam_din),
    .pop_i   (pop),
    .dout_o  (tcam_dout),
    .full_o  (tcam_full),
    .empty_o (tcam_empty)
  );

  // Accumulator state, sticky error flags and the merged registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hit_q      <= 1'b0;
      acc_ptr_q      <= '0;
      acc_multi_q    <= 1'b0;
      acc_hbkt_q     <= 1'b0;
      proto_err_q    <= 1'b0;
      ovf_err_q      <= 1'b0;
      final_vld      <= 1'b0;
      final_err      <= 1'b0;
      final_hit_miss <= 1'b0;
      final_src      <= 1'b0;
      final_ptr      <= '0;
    end else begin
      acc_hit_q   <= acc_hit_d;
      acc_ptr_q   <= acc_ptr_d;
      acc_multi_q <= acc_multi_d;
      acc_hbkt_q  <= acc_hbkt_d;
      proto_err_q <= proto_err_q | (pkt_strobe & busy);
      ovf_err_q   <= ovf_err_q | (hash_push & hash_full & ~pop)
                               | (of_tcam_vld & tcam_full & ~pop);
      final_vld      <= pop;
      final_err      <= 1'b0;
      final_hit_miss <= 1'b0;
      final_src      <= 1'b0;
      final_ptr      <= '0;
      if (pop) begin
        final_err <= hash_dout.err | tcam_dout.err;
        if (hash_dout.hit) begin
          final_hit_miss <= 1'b1;
          final_ptr      <= hash_dout.ptr;
        end else if (tcam_dout.hit) begin
          final_hit_miss <= 1'b1;
          final_src      <= 1'b1;
          final_ptr      <= tcam_dout.ptr;
        end
      end
    end
  end

  assign proto_err = proto_err_q;
  assign ovf_err   = ovf_err_q;

endmodule

// File: tb/tb_class_key_resolve.sv
// Directed bench for class_key_resolve with a VM_LAT-deep value-memory model.
module tb_class_key_resolve;
  import class_pkg::*;

  localparam int KL = 276;
  localparam int AW = 15;
  localparam int NW = 4;
  localparam int VL = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pkt_strobe, pkt_hbkt_err, way_vld;
  logic [AW-1:0] val_ptr, tcam_ptr, final_ptr;
  logic [KL-1:0] key_orig, val_mem_dout_q, mem_ret;
  logic          of_tcam_vld, of_tcam_err, of_tcam_hit_miss;
  logic          final_vld, final_err, final_hit_miss, final_src, proto_err, ovf_err;

  logic [KL-1:0] kval, kbit0, kmsb;
  logic [KL-1:0] vm_pipe [VL];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int            t;
    logic          err;
    logic          hit;
    logic          src;
    logic [AW-1:0] ptr;
  } fin_t;
  fin_t fin_q [$];

  class_key_resolve dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pkt_strobe       (pkt_strobe),
    .pkt_hbkt_err     (pkt_hbkt_err),
    .way_vld          (way_vld),
    .val_ptr          (val_ptr),
    .key_orig         (key_orig),
    .val_mem_dout_q   (val_mem_dout_q),
    .of_tcam_vld      (of_tcam_vld),
    .of_tcam_err      (of_tcam_err),
    .of_tcam_hit_miss (of_tcam_hit_miss),
    .tcam_ptr         (tcam_ptr),
    .final_vld        (final_vld),
    .final_err        (final_err),
    .final_hit_miss   (final_hit_miss),
    .final_src        (final_src),
    .final_ptr        (final_ptr),
    .proto_err        (proto_err),
    .ovf_err          (ovf_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Value memory: returns the data chosen for a beat VL cycles later.
  always @(posedge clk) begin
    vm_pipe[0] <= mem_ret;
    for (int i = 1; i < VL; i++) vm_pipe[i] <= vm_pipe[i-1];
  end
  assign val_mem_dout_q = vm_pipe[VL-1];

  always @(negedge clk) begin
    if (final_vld) fin_q.push_back('{cyc, final_err, final_hit_miss, final_src, final_ptr});
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    pkt_strobe   = 1'b0;
    pkt_hbkt_err = 1'b0;
    way_vld      = 1'b0;
    val_ptr      = '0;
    mem_ret      = '0;
  endtask

  task automatic drive_beat(input logic strobe, input logic hbkt, input logic vld,
                            input logic [AW-1:0] ptr, input logic match, input int idx);
    pkt_strobe   = strobe;
    pkt_hbkt_err = hbkt;
    way_vld      = vld;
    val_ptr      = ptr;
    key_orig     = kval;
    // Non-matching data differs from the key in a single edge bit.
    mem_ret      = match ? kval : (((idx % 2) == 0) ? (kval ^ kbit0) : (kval ^ kmsb));
    @(posedge clk); #1;
  endtask

  task automatic lookup(input logic hbkt, input logic [NW-1:0] vmask, input logic [NW-1:0] match,
                        input logic [NW*AW-1:0] ptrs, input logic [NW-1:0] extra_strobe,
                        output int t0);
    t0 = cyc;
    for (int i = 0; i < NW; i++)
      drive_beat((i == 0) | extra_strobe[i], (i == 0) & hbkt, vmask[i], ptrs[i*AW +: AW], match[i], i);
    clear_inputs();
  endtask

  task automatic tcam_push(input logic hit, input logic err, input logic [AW-1:0] ptr);
    of_tcam_vld      = 1'b1;
    of_tcam_hit_miss = hit;
    of_tcam_err      = err;
    tcam_ptr         = ptr;
    @(posedge clk); #1;
    of_tcam_vld      = 1'b0;
    of_tcam_hit_miss = 1'b0;
    of_tcam_err      = 1'b0;
    tcam_ptr         = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic wait_final(input string tag, input int budget, output fin_t r);
    int n = 0;
    r = '{-1, 1'b0, 1'b0, 1'b0, '0};
    while (fin_q.size() == 0 && n < budget) begin @(posedge clk); #1; n++; end
    if (fin_q.size() == 0) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    else r = fin_q.pop_front();
  endtask

  task automatic check_final(input string tag, input fin_t r, input int exp_t,
                             input logic err, input logic hit, input logic src,
                             input logic [AW-1:0] ptr);
    if (exp_t >= 0) check_eq({tag, "_time"}, r.t, exp_t);
    check_eq({tag, "_err"}, {31'd0, r.err}, {31'd0, err});
    check_eq({tag, "_hit"}, {31'd0, r.hit}, {31'd0, hit});
    check_eq({tag, "_src"}, {31'd0, r.src}, {31'd0, src});
    check_eq({tag, "_ptr"}, {17'd0, r.ptr}, {17'd0, ptr});
    $display("txn %s: t=%0d err=%0b hit=%0b src=%0b ptr=0x%0h", tag, r.t, r.err, r.hit, r.src, r.ptr);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_vld"},   {31'd0, final_vld},      32'd0);
    check_eq({tag, "_err"},   {31'd0, final_err},      32'd0);
    check_eq({tag, "_hit"},   {31'd0, final_hit_miss}, 32'd0);
    check_eq({tag, "_src"},   {31'd0, final_src},      32'd0);
    check_eq({tag, "_ptr"},   {17'd0, final_ptr},      32'd0);
    check_eq({tag, "_proto"}, {31'd0, proto_err},      32'd0);
    check_eq({tag, "_ovf"},   {31'd0, ovf_err},        32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   t0;
    fin_t r;
    kval  = {12'hABC, {8{32'hDEADBEEF}}, 8'h5A};
    kbit0 = '0;
    kbit0[0] = 1'b1;
    kmsb  = '0;
    kmsb[KL-1] = 1'b1;
    key_orig = kval;
    clear_inputs();
    of_tcam_vld = 1'b0; of_tcam_err = 1'b0; of_tcam_hit_miss = 1'b0; tcam_ptr = '0;
    rst_n = 1'b0;
    idle(3);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    idle(2);

    // Hash hit on way 2 with TCAM miss already queued.
    tcam_push(1'b0, 1'b0, 15'h055);
    idle(1);
    lookup(1'b0, 4'hF, 4'b0100, {15'h003, 15'h123, 15'h002, 15'h001}, 4'b0000, t0);
    wait_final("hash_hit", 30, r);
    check_final("hash_hit", r, t0 + 10, 1'b0, 1'b1, 1'b0, 15'h123);

    // No way matches; TCAM hit arrives at T+20.
    lookup(1'b0, 4'hF, 4'b0000, {15'h004, 15'h003, 15'h002, 15'h001}, 4'b0000, t0);
    while (cyc < t0 + 20) begin @(posedge clk); #1; end
    tcam_push(1'b1, 1'b0, 15'h7FF);
    wait_final("tcam_hit", 30, r);
    check_final("tcam_hit", r, t0 + 22, 1'b0, 1'b1, 1'b1, 15'h7FF);

    // Ways 1 and 3 both match: lowest way wins, multi-match flags error.
    tcam_push(1'b0, 1'b0, 15'h000);
    lookup(1'b0, 4'hF, 4'b1010, {15'h030, 15'h020, 15'h010, 15'h005}, 4'b0000, t0);
    wait_final("multi", 30, r);
    check_final("multi", r, t0 + 10, 1'b1, 1'b1, 1'b0, 15'h010);

    // Bucket error, no matches.
    tcam_push(1'b0, 1'b0, 15'h000);
    lookup(1'b1, 4'hF, 4'b0000, {15'h030, 15'h020, 15'h010, 15'h005}, 4'b0000, t0);
    wait_final("hbkt", 30, r);
    check_final("hbkt", r, t0 + 10, 1'b1, 1'b0, 1'b0, 15'h000);

    // Key matches on an unoccupied way 1 must not count; way 3 wins alone.
    tcam_push(1'b0, 1'b0, 15'h000);
    lookup(1'b0, 4'b1101, 4'b1010, {15'h030, 15'h020, 15'h010, 15'h005}, 4'b0000, t0);
    wait_final("vld_gate", 30, r);
    check_final("vld_gate", r, t0 + 10, 1'b0, 1'b1, 1'b0, 15'h030);

    // TCAM error with both sides hitting: hash keeps priority, error merges.
    tcam_push(1'b1, 1'b1, 15'h222);
    lookup(1'b0, 4'hF, 4'b0001, {15'h004, 15'h003, 15'h002, 15'h005}, 4'b0000, t0);
    wait_final("tcam_err", 30, r);
    check_final("tcam_err", r, t0 + 10, 1'b1, 1'b1, 1'b0, 15'h005);
    check_eq("proto_before", {31'd0, proto_err}, 32'd0);

    // Second strobe inside a lookup is ignored and flagged.
    tcam_push(1'b0, 1'b0, 15'h000);
    tcam_push(1'b0, 1'b0, 15'h000);
    lookup(1'b0, 4'hF, 4'b0001, {15'h004, 15'h003, 15'h002, 15'h044}, 4'b0100, t0);
    wait_final("proto", 30, r);
    check_final("proto", r, t0 + 10, 1'b0, 1'b1, 1'b0, 15'h044);
    idle(20);
    check_eq("proto_single", fin_q.size(), 32'd0);
    check_eq("proto_flag", {31'd0, proto_err}, 32'd1);

    // Reset flushes the leftover TCAM entry and the sticky flag.
    rst_n = 1'b0;
    idle(2);
    check_eq("proto_cleared", {31'd0, proto_err}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Five lookups, no TCAM: the fifth push overflows the hash FIFO.
    lookup(1'b0, 4'hF, 4'b0001, {4{15'h100}}, 4'b0000, t0);
    for (int k = 1; k < 5; k++) begin
      int tk;
      logic [NW-1:0] m;
      m = '0;
      m[k % NW] = 1'b1;
      lookup(1'b0, 4'hF, m, {4{15'(15'h100 + k)}}, 4'b0000, tk);
    end
    while (cyc < t0 + 22) begin @(posedge clk); #1; end
    check_eq("ovf_before", {31'd0, ovf_err}, 32'd0);
    while (cyc < t0 + 26) begin @(posedge clk); #1; end
    check_eq("ovf_after", {31'd0, ovf_err}, 32'd1);
    for (int k = 0; k < 4; k++) tcam_push(1'b0, 1'b0, 15'h000);
    for (int k = 0; k < 4; k++) begin
      wait_final($sformatf("drain%0d", k), 20, r);
      check_final($sformatf("drain%0d", k), r, -1, 1'b0, 1'b1, 1'b0, 15'(15'h100 + k));
    end
    idle(20);
    check_eq("drain_extra", fin_q.size(), 32'd0);

    // Reset in the middle of a lookup.
    tcam_push(1'b0, 1'b0, 15'h000);
    drive_beat(1'b1, 1'b0, 1'b1, 15'h066, 1'b1, 0);
    drive_beat(1'b0, 1'b0, 1'b1, 15'h067, 1'b0, 1);
    drive_beat(1'b0, 1'b0, 1'b1, 15'h068, 1'b0, 2);
    way_vld = 1'b1; val_ptr = 15'h069;
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    @(posedge clk); #1;
    clear_inputs();
    rst_n = 1'b1;
    tcam_push(1'b0, 1'b0, 15'h000);
    idle(20);
    check_eq("rst_no_final", fin_q.size(), 32'd0);
    lookup(1'b0, 4'hF, 4'b0001, {15'h004, 15'h003, 15'h002, 15'h077}, 4'b0000, t0);
    wait_final("post_rst", 30, r);
    check_final("post_rst", r, t0 + 10, 1'b0, 1'b1, 1'b0, 15'h077);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
